// File: rtl/bram_stream_ctrl.sv
// bram_stream_ctrl: sequencer in front of a single-port BRAM with a combinational read port.
// It records a valid/ready sample stream into the RAM and plays it back on a
// valid/ready output stream. It also issues a one-cycle RAM clear/reload.
// Define BRAM_CTRL_LOOP_EN to make playback repeat until STOP. Without it,
// playback makes a single pass.
module bram_stream_ctrl #(
   parameter  int BITWIDTH = 12,
   parameter  int RAMWIDTH = 32,
   localparam int AW       = $clog2(RAMWIDTH),
   localparam int CW       = AW + 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                START_REC,
   input  logic                START_PLAY,
   input  logic                CLEAR,
   input  logic                STOP,
   input  logic                S_VALID,
   output logic                S_READY,
   input  logic [BITWIDTH-1:0] S_DATA,
   output logic                M_VALID,
   input  logic                M_READY,
   output logic [BITWIDTH-1:0] M_DATA,
   output logic                BUSY,
   output logic                FULL,
   output logic [CW-1:0]       COUNT,
   output logic                RAM_EN,
   output logic                RAM_WE,
   output logic [AW-1:0]       RAM_ADR,
   output logic [BITWIDTH-1:0] RAM_DIN,
   input  logic [BITWIDTH-1:0] RAM_DOUT
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECORD,
      ST_PLAY,
      ST_CLEAR
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       count_q, count_d;
   logic [CW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [BITWIDTH-1:0] m_data_q, m_data_d;
   logic                m_valid_q, m_valid_d;
   logic                stop_q, stop_d;
   logic                stopping;
   logic                accept;

   // State register and datapath flops
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         stop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         stop_q    <= stop_d;
      end
   end

   // Next-state logic, RAM write/address pins and stream handshakes
   always_comb begin
      // NOTE: every signal written here gets a default first. Without it, a
      // branch that skips an assignment would infer a latch.
      state_d   = state_q;
      count_d   = count_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      stop_d    = stop_q;
      stopping  = 1'b0;
      accept    = 1'b0;
      S_READY   = 1'b0;
      RAM_WE    = 1'b0;
      RAM_ADR   = '0;
      RAM_DIN   = '0;

      case (state_q)
         ST_IDLE: begin
            if (CLEAR) begin
               state_d = ST_CLEAR;
            end else if (START_REC) begin
               state_d  = ST_RECORD;
               wr_ptr_d = '0;
               count_d  = '0;
            end else if (START_PLAY && (count_q != '0)) begin
               state_d  = ST_PLAY;
               rd_ptr_d = '0;
               stop_d   = 1'b0;
            end
         end

         ST_CLEAR: begin
            count_d = '0;
            state_d = ST_IDLE;
         end

         ST_RECORD: begin
            S_READY = 1'b1;
            RAM_WE  = S_VALID;
            RAM_ADR = wr_ptr_q[AW-1:0];
            RAM_DIN = S_DATA;
            if (S_VALID) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               count_d  = count_q + 1'b1;
            end
            // A STOP that arrives with a handshake still keeps that sample.
            if (STOP || (S_VALID && (count_q == CW'(RAMWIDTH - 1)))) begin
               state_d = ST_IDLE;
            end
         end

         ST_PLAY: begin
            RAM_ADR = rd_ptr_q[AW-1:0];
            // STOP may be a pulse. Latch it so a stalled beat can still drain.
            stopping = STOP || stop_q;
            stop_d   = stopping;
            accept   = m_valid_q && M_READY;
            if ((!m_valid_q || M_READY) && (rd_ptr_q < count_q) && !stopping) begin
               m_data_d  = RAM_DOUT;
               m_valid_d = 1'b1;
`ifdef BRAM_CTRL_LOOP_EN
               rd_ptr_d  = ((rd_ptr_q + 1'b1) == count_q) ? '0 : rd_ptr_q + 1'b1;
`else
               rd_ptr_d  = rd_ptr_q + 1'b1;
`endif
            end else if (accept) begin
               m_valid_d = 1'b0;
            end
`ifndef BRAM_CTRL_LOOP_EN
            if (accept && (rd_ptr_q == count_q)) begin
               state_d = ST_IDLE;
            end
`endif
            if (stopping && (!m_valid_q || accept)) begin
               m_valid_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // The RAM is disabled during CLEAR, and combinationally while reset is asserted.
   assign RAM_EN  = !RST && (state_q != ST_CLEAR);
   assign BUSY    = (state_q != ST_IDLE);
   assign FULL    = (count_q == CW'(RAMWIDTH));
   assign COUNT   = count_q;
   assign M_VALID = m_valid_q;
   assign M_DATA  = m_data_q;

endmodule

// File: tb/tb_bram_stream_ctrl.sv
// Directed testbench for bram_stream_ctrl. It includes a behavioural BRAM:
// the RAM writes on the negedge and reads combinationally.
// Build with BRAM_CTRL_LOOP_EN defined to also exercise looping playback.
module tb_bram_stream_ctrl;

   localparam int BW = 12;
   localparam int RW = 32;
   localparam int AW = $clog2(RW);
   localparam int CW = AW + 1;

   logic          CLK = 1'b0;
   logic          RST;
   logic          START_REC, START_PLAY, CLEAR, STOP;
   logic          S_VALID, S_READY;
   logic [BW-1:0] S_DATA;
   logic          M_VALID, M_READY;
   logic [BW-1:0] M_DATA;
   logic          BUSY, FULL;
   logic [CW-1:0] COUNT;
   logic          RAM_EN, RAM_WE;
   logic [AW-1:0] RAM_ADR;
   logic [BW-1:0] RAM_DIN, RAM_DOUT;

   logic [BW-1:0] mem [RW];
   int passed = 0;
   int total  = 0;

   bram_stream_ctrl #(.BITWIDTH(BW), .RAMWIDTH(RW)) dut (
      .CLK(CLK), .RST(RST),
      .START_REC(START_REC), .START_PLAY(START_PLAY), .CLEAR(CLEAR), .STOP(STOP),
      .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
      .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
      .BUSY(BUSY), .FULL(FULL), .COUNT(COUNT),
      .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADR(RAM_ADR),
      .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT)
   );

   always #5 CLK = ~CLK;

   // Behavioural single-port RAM
   always @(negedge CLK) if (RAM_EN && RAM_WE) mem[RAM_ADR] <= RAM_DIN;
   assign RAM_DOUT = (RAM_EN && !RAM_WE) ? mem[RAM_ADR] : '0;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      RST = 1'b1;
      START_REC = 0; START_PLAY = 0; CLEAR = 0; STOP = 0;
      S_VALID = 0; S_DATA = '0; M_READY = 0;
      for (int i = 0; i < RW; i++) mem[i] = '0;
      tick; tick; tick;
      total++;
      if ({RAM_EN, RAM_WE, BUSY, FULL, S_READY, M_VALID} !== 6'b0)
         $display("FAIL reset_flags: got %b expected 000000",
                  {RAM_EN, RAM_WE, BUSY, FULL, S_READY, M_VALID});
      else passed++;
      total++;
      if ({COUNT, RAM_ADR, RAM_DIN, M_DATA} !== '0)
         $display("FAIL reset_values: count=%0d adr=%0d din=%h mdata=%h expected all 0",
                  COUNT, RAM_ADR, RAM_DIN, M_DATA);
      else passed++;
      RST = 1'b0;
      tick;
      total++;
      if (RAM_EN !== 1'b1 || BUSY !== 1'b0)
         $display("FAIL reset_release: ram_en=%b busy=%b expected 1/0", RAM_EN, BUSY);
      else passed++;
   endtask

   task automatic test_reset_mid_record;
      START_REC = 1; tick; START_REC = 0;
      total++;
      if (BUSY !== 1'b1 || S_READY !== 1'b1)
         $display("FAIL rec_entry: busy=%b s_ready=%b expected 1/1", BUSY, S_READY);
      else passed++;
      S_VALID = 1; S_DATA = 12'h055; tick;
      S_DATA = 12'h066; tick;
      S_DATA = 12'h077; RST = 1'b1; #1;
      total++;
      if (RAM_EN !== 1'b0 || RAM_WE !== 1'b0)
         $display("FAIL rst_ram_pins: en=%b we=%b expected 0/0", RAM_EN, RAM_WE);
      else passed++;
      tick; tick; tick;
      total++;
      if ({BUSY, S_READY, M_VALID} !== 3'b0 || COUNT !== '0)
         $display("FAIL rst_mid_rec: busy=%b s_ready=%b m_valid=%b count=%0d expected 0",
                  BUSY, S_READY, M_VALID, COUNT);
      else passed++;
      RST = 1'b0; S_VALID = 0; tick;
      total++;
      if (RAM_EN !== 1'b1 || mem[0] !== 12'h055 || mem[1] !== 12'h066 || mem[2] !== 12'h000)
         $display("FAIL rst_ram_kept: en=%b mem0=%h mem1=%h mem2=%h expected 1 055 066 000",
                  RAM_EN, mem[0], mem[1], mem[2]);
      else passed++;
   endtask

   task automatic test_full_record_play;
      START_REC = 1; tick; START_REC = 0;
      for (int i = 1; i <= RW; i++) begin
         S_VALID = 1; S_DATA = BW'(i);
         if (i == 1) begin
            #1;
            total++;
            if (RAM_WE !== 1'b1 || RAM_ADR !== '0 || RAM_DIN !== 12'h001)
               $display("FAIL rec_pins: we=%b adr=%0d din=%h expected 1 0 001",
                        RAM_WE, RAM_ADR, RAM_DIN);
            else passed++;
         end
         if (i == RW) begin
            total++;
            if (S_READY !== 1'b1 || FULL !== 1'b0 || COUNT !== CW'(RW - 1))
               $display("FAIL rec_before_full: s_ready=%b full=%b count=%0d expected 1 0 31",
                        S_READY, FULL, COUNT);
            else passed++;
         end
         tick;
      end
      S_VALID = 0;
      total++;
      if (COUNT !== CW'(RW) || FULL !== 1'b1 || S_READY !== 1'b0 || BUSY !== 1'b0)
         $display("FAIL rec_full: count=%0d full=%b s_ready=%b busy=%b expected 32 1 0 0",
                  COUNT, FULL, S_READY, BUSY);
      else passed++;
      M_READY = 1; START_PLAY = 1; tick; START_PLAY = 0;
      total++;
      if (M_VALID !== 1'b0 || BUSY !== 1'b1)
         $display("FAIL play_latency: m_valid=%b busy=%b expected 0 1", M_VALID, BUSY);
      else passed++;
      tick;
      for (int i = 1; i <= RW; i++) begin
         total++;
         if (M_VALID !== 1'b1 || M_DATA !== BW'(i))
            $display("FAIL play_beat_%0d: valid=%b data=%h expected 1 %h", i, M_VALID, M_DATA, BW'(i));
         else passed++;
         tick;
      end
      total++;
      if (M_VALID !== 1'b0 || BUSY !== 1'b0)
         $display("FAIL play_end: m_valid=%b busy=%b expected 0 0", M_VALID, BUSY);
      else passed++;
   endtask

   task automatic test_stop_stall;
      int idx;
      idx = 0;
      M_READY = 0;
      START_REC = 1; tick; START_REC = 0;
      for (int i = 0; i < 5; i++) begin
         S_VALID = 1; S_DATA = BW'(12'hA00 + i); STOP = (i == 4);
         tick;
      end
      S_VALID = 0; STOP = 0;
      total++;
      if (COUNT !== CW'(5) || BUSY !== 1'b0)
         $display("FAIL stop_rec: count=%0d busy=%b expected 5 0", COUNT, BUSY);
      else passed++;
      START_PLAY = 1; tick; START_PLAY = 0;
      for (int c = 0; c < 30; c++) begin
         M_READY = ((c % 3) == 0);
         #1;
         if (M_VALID) begin
            total++;
            if (idx >= 5 || M_DATA !== BW'(12'hA00 + idx))
               $display("FAIL stall_beat_c%0d: data=%h expected %h (beat %0d of 5)",
                        c, M_DATA, BW'(12'hA00 + idx), idx);
            else passed++;
            if (M_READY) idx++;
         end
         tick;
      end
      M_READY = 0;
      total++;
      if (idx !== 5 || BUSY !== 1'b0 || M_VALID !== 1'b0 || M_DATA !== 12'hA04)
         $display("FAIL stall_end: beats=%0d busy=%b valid=%b data=%h expected 5 0 0 a04",
                  idx, BUSY, M_VALID, M_DATA);
      else passed++;
   endtask

   task automatic test_clear;
      CLEAR = 1; tick; CLEAR = 0;
      total++;
      if (RAM_EN !== 1'b0 || RAM_WE !== 1'b0 || BUSY !== 1'b1)
         $display("FAIL clear_cycle: en=%b we=%b busy=%b expected 0 0 1", RAM_EN, RAM_WE, BUSY);
      else passed++;
      tick;
      total++;
      if (RAM_EN !== 1'b1 || COUNT !== '0 || BUSY !== 1'b0)
         $display("FAIL clear_done: en=%b count=%0d busy=%b expected 1 0 0", RAM_EN, COUNT, BUSY);
      else passed++;
      START_PLAY = 1; tick; START_PLAY = 0;
      total++;
      if (BUSY !== 1'b0)
         $display("FAIL play_empty_ignored: busy=%b expected 0", BUSY);
      else passed++;
      START_REC = 1; tick; START_REC = 0;
      S_VALID = 1; S_DATA = 12'h123; STOP = 1; tick;
      S_VALID = 0; STOP = 0;
      total++;
      if (COUNT !== CW'(1))
         $display("FAIL rec_one: count=%0d expected 1", COUNT);
      else passed++;
      M_READY = 1; START_PLAY = 1; tick; START_PLAY = 0; tick;
      total++;
      if (M_VALID !== 1'b1 || M_DATA !== 12'h123)
         $display("FAIL play_one: valid=%b data=%h expected 1 123", M_VALID, M_DATA);
      else passed++;
      tick;
      total++;
      if (BUSY !== 1'b0 || M_VALID !== 1'b0)
         $display("FAIL play_one_end: busy=%b valid=%b expected 0 0", BUSY, M_VALID);
      else passed++;
      M_READY = 0;
   endtask

   task automatic test_priority;
      CLEAR = 1; START_REC = 1; START_PLAY = 1; tick;
      CLEAR = 0; START_REC = 0; START_PLAY = 0;
      total++;
      if (RAM_EN !== 1'b0 || S_READY !== 1'b0 || M_VALID !== 1'b0)
         $display("FAIL prio_clear: en=%b s_ready=%b m_valid=%b expected 0 0 0",
                  RAM_EN, S_READY, M_VALID);
      else passed++;
      tick;
      total++;
      if (COUNT !== '0 || BUSY !== 1'b0)
         $display("FAIL prio_clear_done: count=%0d busy=%b expected 0 0", COUNT, BUSY);
      else passed++;
      START_REC = 1; tick; START_REC = 0;
      S_VALID = 1; S_DATA = 12'h0AB; STOP = 1; tick;
      S_VALID = 0; STOP = 0;
      START_PLAY = 1; tick; START_PLAY = 0; tick;
      START_REC = 1; tick; START_REC = 0;
      total++;
      if (S_READY !== 1'b0 || M_VALID !== 1'b1 || M_DATA !== 12'h0AB || BUSY !== 1'b1)
         $display("FAIL rec_in_play_ignored: s_ready=%b valid=%b data=%h busy=%b expected 0 1 0ab 1",
                  S_READY, M_VALID, M_DATA, BUSY);
      else passed++;
      M_READY = 1; tick;
      total++;
      if (BUSY !== 1'b0 || M_VALID !== 1'b0 || COUNT !== CW'(1))
         $display("FAIL prio_drain: busy=%b valid=%b count=%0d expected 0 0 1", BUSY, M_VALID, COUNT);
      else passed++;
      M_READY = 0;
   endtask

`ifdef BRAM_CTRL_LOOP_EN
   task automatic test_loop;
      logic [BW-1:0] seq [6];
      seq = '{12'h7, 12'h8, 12'h9, 12'h7, 12'h8, 12'h9};
      START_REC = 1; tick; START_REC = 0;
      for (int i = 0; i < 3; i++) begin
         S_VALID = 1; S_DATA = BW'(7 + i); STOP = (i == 2);
         tick;
      end
      S_VALID = 0; STOP = 0;
      M_READY = 1; START_PLAY = 1; tick; START_PLAY = 0; tick;
      for (int j = 0; j < 6; j++) begin
         total++;
         if (M_VALID !== 1'b1 || M_DATA !== seq[j])
            $display("FAIL loop_beat_%0d: valid=%b data=%h expected 1 %h", j, M_VALID, M_DATA, seq[j]);
         else passed++;
         tick;
      end
      M_READY = 0; STOP = 1;
      total++;
      if (M_VALID !== 1'b1 || M_DATA !== 12'h7)
         $display("FAIL loop_held: valid=%b data=%h expected 1 007", M_VALID, M_DATA);
      else passed++;
      tick;
      STOP = 0; M_READY = 1;
      total++;
      if (M_VALID !== 1'b1 || M_DATA !== 12'h7 || BUSY !== 1'b1)
         $display("FAIL loop_stop_hold: valid=%b data=%h busy=%b expected 1 007 1", M_VALID, M_DATA, BUSY);
      else passed++;
      tick;
      total++;
      if (M_VALID !== 1'b0 || BUSY !== 1'b0)
         $display("FAIL loop_stop_end: valid=%b busy=%b expected 0 0", M_VALID, BUSY);
      else passed++;
      M_READY = 0;
   endtask
`endif

   initial begin
      test_reset;
      test_reset_mid_record;
      test_full_record_play;
      test_stop_stall;
      test_clear;
      test_priority;
`ifdef BRAM_CTRL_LOOP_EN
      test_loop;
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
